sincpde_div_param: RTL and testbench

Parametrised, multi-cycle signed fixed-point divider for the sincpde datapath. It computes Q = trunc(N·2^QF / D) one quotient bit per cycle using restoring shift/subtract in fabric logic, with no DSP primitive. It adds a remainder output, saturation, divide-by-zero and overflow flags, and a fixed deterministic latency. It uses the same SYNC_IN/SYNC_OUT pulse protocol as the other sincpde pipeline blocks.

---
 rtl/sincpde_div_pkg.sv | 22 ++
 rtl/sincpde_div_sat.sv | 53 +++++
 rtl/sincpde_div_param.sv | 138 +++++++++++++
 tb/tb_sincpde_div_param.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sincpde_div_pkg.sv
// Shared state type and helpers for the sincpde restoring divider.
// Helpers work on MAXW-bit sign-extended operands so one copy serves every width.
package sincpde_div_pkg;

  localparam int MAXW = 128;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  function automatic logic signed [63:0] qmax(input int qw);
    return (64'sd1 <<< (qw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] qmin(input int qw);
    return -(64'sd1 <<< (qw - 1));
  endfunction

  // The extra headroom above the operand width keeps -(most negative) exact.
  function automatic logic [MAXW-1:0] absw(input logic signed [MAXW-1:0] v);
    return v[MAXW-1] ? MAXW'(-v) : MAXW'(v);
  endfunction

endpackage

// File: rtl/sincpde_div_sat.sv
// Sign-apply and saturation of the divider magnitude; combinational, no flow control.
// With SINCPDE_DIV_ROUND_EN defined the magnitude is rounded half away from zero first.
module sincpde_div_sat
  import sincpde_div_pkg::*;
#(
  parameter int QW = 18,
  parameter int DW = 48,
  parameter int RW = 57
) (
  input  logic [QW-1:0]        i_mag,
  input  logic [RW-1:0]        i_rem,
  input  logic [DW:0]          i_dabs,
  input  logic                 i_negq,
  input  logic                 i_negr,
  input  logic                 i_pre_ovf,
  input  logic                 i_dz,
  output logic signed [QW-1:0] o_q,
  output logic                 o_ovf
);

  localparam int MW = QW + 1;
  localparam logic signed [QW-1:0] QMAX    = QW'(qmax(QW));
  localparam logic signed [QW-1:0] QMIN    = QW'(qmin(QW));
  localparam logic [MW-1:0]        LIM_POS = MW'(qmax(QW));
  localparam logic [MW-1:0]        LIM_NEG = MW'(-qmin(QW));

  logic [MW-1:0] w_mag;
  logic          w_ovf;

`ifdef SINCPDE_DIV_ROUND_EN
  localparam int XW = (RW + 1 > DW + 1) ? RW + 1 : DW + 1;
  logic w_round_up;
  assign w_round_up = XW'({i_rem, 1'b0}) >= XW'(i_dabs);
  assign w_mag      = {1'b0, i_mag} + MW'(w_round_up);
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^{i_rem, i_dabs};
  assign w_mag        = {1'b0, i_mag};
`endif

  always_comb begin
    w_ovf = i_pre_ovf || (i_negq ? (w_mag > LIM_NEG) : (w_mag > LIM_POS));
    o_ovf = 1'b0;
    o_q   = i_negq ? QW'(-w_mag) : QW'(w_mag);
    if (i_dz) begin
      o_q = i_negr ? QMIN : QMAX;
    end else if (w_ovf) begin
      o_q   = i_negq ? QMIN : QMAX;
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/sincpde_div_param.sv
// Signed fixed-point restoring divider Q = trunc(N*2^QF/D), one quotient bit per cycle.
// Result pulses SYNC_OUT QW+2 cycles after SYNC_IN; no backpressure, SYNC_IN restarts; SINCPDE_DIV_ROUND_EN adds rounding.
module sincpde_div_param
  import sincpde_div_pkg::*;
#(
  parameter int NW = 48,
  parameter int DW = 48,
  parameter int QW = 18,
  parameter int QF = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SYNC_IN,
  input  logic signed [NW-1:0] N,
  input  logic signed [DW-1:0] D,
  output logic signed [QW-1:0] Q,
  output logic signed [DW-1:0] REM,
  output logic                 OVF,
  output logic                 DZ,
  output logic                 BUSY,
  output logic                 SYNC_OUT
);

  localparam int RW  = NW + QF + 1;
  localparam int AW  = DW + 1;
  localparam int NAW = NW + 1;
  localparam int CW  = (RW > AW + QW) ? RW : AW + QW;
  localparam int IW  = $clog2(QW);

  state_t               r_state;
  logic signed [NW-1:0] r_n;
  logic signed [DW-1:0] r_d;
  logic                 r_negq;
  logic                 r_negr;
  logic                 r_dz;
  logic                 r_pre_ovf;
  logic [RW-1:0]        r_rem;
  logic [AW-1:0]        r_dabs;
  logic [QW-1:0]        r_mag;
  logic [IW-1:0]        r_i;

  logic [NAW-1:0]       w_nabs;
  logic [AW-1:0]        w_dabs;
  logic [RW-1:0]        w_r0;
  logic [CW-1:0]        w_rext;
  logic [CW-1:0]        w_dsh;
  logic [CW-1:0]        w_diff;
  logic                 w_ge;
  logic [DW-1:0]        w_rem_t;
  logic signed [QW-1:0] w_q;
  logic                 w_ovf;

  assign w_nabs  = NAW'(absw(MAXW'(r_n)));
  assign w_dabs  = AW'(absw(MAXW'(r_d)));
  assign w_r0    = RW'(w_nabs) << QF;
  assign w_rext  = CW'(r_rem);
  assign w_dsh   = CW'(r_dabs) << r_i;
  assign w_ge    = w_rext >= w_dsh;
  assign w_diff  = w_rext - w_dsh;
  // After the last step the partial remainder is below |D|, so DW bits hold it.
  assign w_rem_t = r_rem[DW-1:0];

  sincpde_div_sat #(
    .QW(QW),
    .DW(DW),
    .RW(RW)
  ) u_sat (
    .i_mag    (r_mag),
    .i_rem    (r_rem),
    .i_dabs   (r_dabs),
    .i_negq   (r_negq),
    .i_negr   (r_negr),
    .i_pre_ovf(r_pre_ovf),
    .i_dz     (r_dz),
    .o_q      (w_q),
    .o_ovf    (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_d       <= '0;
      r_negq    <= 1'b0;
      r_negr    <= 1'b0;
      r_dz      <= 1'b0;
      r_pre_ovf <= 1'b0;
      r_rem     <= '0;
      r_dabs    <= '0;
      r_mag     <= '0;
      r_i       <= '0;
      Q         <= '0;
      REM       <= '0;
      OVF       <= 1'b0;
      DZ        <= 1'b0;
      BUSY      <= 1'b0;
      SYNC_OUT  <= 1'b0;
    end else begin
      SYNC_OUT <= 1'b0;
      case (r_state)
        IDLE: BUSY <= 1'b0;
        PREP: begin
          r_rem     <= w_r0;
          r_dabs    <= w_dabs;
          r_dz      <= (r_d == '0);
          r_pre_ovf <= CW'(w_r0) >= (CW'(w_dabs) << QW);
          r_i       <= IW'(QW - 1);
          r_state   <= ITER;
        end
        ITER: begin
          if (w_ge) r_rem <= RW'(w_diff);
          r_mag[r_i] <= w_ge;
          r_i        <= r_i - IW'(1);
          if (r_i == '0) r_state <= FIX;
        end
        FIX: begin
          Q        <= w_q;
          OVF      <= w_ovf;
          DZ       <= r_dz;
          REM      <= r_dz ? '0 : (r_negr ? -w_rem_t : w_rem_t);
          SYNC_OUT <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A new start overrides whatever the FSM was doing; FIX outputs above still land.
      if (SYNC_IN) begin
        r_n     <= N;
        r_d     <= D;
        r_negq  <= N[NW-1] ^ D[DW-1];
        r_negr  <= N[NW-1];
        BUSY    <= 1'b1;
        r_state <= PREP;
      end
    end
  end

endmodule

// File: tb/tb_sincpde_div_param.sv
// Directed table bench for sincpde_div_param at default parameters, plus restart/reset sequences.
module tb_sincpde_div_param;

  localparam int NW  = 48;
  localparam int DW  = 48;
  localparam int QW  = 18;
  localparam int LAT = QW + 2;
`ifdef SINCPDE_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sync_in;
  logic signed [NW-1:0] n_in;
  logic signed [DW-1:0] d_in;
  logic signed [QW-1:0] q;
  logic signed [DW-1:0] rem;
  logic                 ovf;
  logic                 dz;
  logic                 busy;
  logic                 sync_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string                name;
    logic signed [NW-1:0] n;
    logic signed [DW-1:0] d;
    logic signed [QW-1:0] q;
    logic signed [DW-1:0] rem;
    bit                   chk_rem;
    logic                 ovf;
    logic                 dz;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  sincpde_div_param dut (
    .clk     (clk),
    .rst     (rst),
    .SYNC_IN (sync_in),
    .N       (n_in),
    .D       (d_in),
    .Q       (q),
    .REM     (rem),
    .OVF     (ovf),
    .DZ      (dz),
    .BUSY    (busy),
    .SYNC_OUT(sync_out)
  );

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic signed [NW-1:0] n, input logic signed [DW-1:0] d);
    sync_in = 1'b1;
    n_in    = n;
    d_in    = d;
    tick();
    sync_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".q"},        64'(q),        64'sd0);
    chk({tag, ".rem"},      64'(rem),      64'sd0);
    chk({tag, ".ovf"},      64'(ovf),      64'sd0);
    chk({tag, ".dz"},       64'(dz),       64'sd0);
    chk({tag, ".busy"},     64'(busy),     64'sd0);
    chk({tag, ".sync_out"}, 64'(sync_out), 64'sd0);
  endtask

  task automatic run_vec(input vec_t v);
    start(v.n, v.d);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk({v.name, ".busy"},     64'(busy),     64'(k <= LAT));
      chk({v.name, ".sync_out"}, 64'(sync_out), 64'(k == LAT));
      if (k == LAT) begin
        chk({v.name, ".q"},   64'(q),   64'(v.q));
        chk({v.name, ".ovf"}, 64'(ovf), 64'(v.ovf));
        chk({v.name, ".dz"},  64'(dz),  64'(v.dz));
        if (v.chk_rem) chk({v.name, ".rem"}, 64'(rem), 64'(v.rem));
      end
    end
  endtask

  initial begin
    int pulses;
    int at;
    int busy_hi;
    logic signed [QW-1:0] q_at;
    logic signed [DW-1:0] rem_at;

    vecs[0]  = '{"p100_d7",    48'sd100,             48'sd7,               18'sd3657,       48'sd1,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"m100_d7",   -48'sd100,             48'sd7,              -18'sd3657,      -48'sd1,  1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"p100_dm7",   48'sd100,            -48'sd7,              -18'sd3657,       48'sd1,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"ovf_1000",   48'sd1000,            48'sd1,               18'sd131071,     48'sd0,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{"min_m512",  -48'sd512,             48'sd1,               18'sh20000,      48'sd0,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"max_p512",   48'sd512,             48'sd1,               18'sd131071,     48'sd0,  1'b1, 1'b1, 1'b0};
    vecs[6]  = '{"dz_m5",     -48'sd5,               48'sd0,               18'sh20000,      48'sd0,  1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"dz_0",       48'sd0,               48'sd0,               18'sd131071,     48'sd0,  1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"r_2_3",      48'sd2,               48'sd3,               QW'(170 + RND),  48'sd2,  1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"r_1_3",      48'sd1,               48'sd3,               18'sd85,         48'sd1,  1'b1, 1'b0, 1'b0};
    vecs[10] = '{"r_m2_3",    -48'sd2,               48'sd3,               QW'(-170 - RND), -48'sd2, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"ext_min",    48'sh8000_0000_0000,  48'sh8000_0000_0000,  18'sd256,        48'sd0,  1'b1, 1'b0, 1'b0};
    vecs[12] = '{"ext_min_1",  48'sh8000_0000_0000,  48'sd1,               18'sh20000,      48'sd0,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{"zero_n",     48'sd0,               48'sd5,               18'sd0,          48'sd0,  1'b1, 1'b0, 1'b0};

    // Reset with SYNC_IN held high: reset must win and nothing may start.
    rst     = 1'b1;
    sync_in = 1'b1;
    n_in    = 48'sd100;
    d_in    = 48'sd7;
    tick();
    tick();
    tick();
    chk_zero("reset");
    rst     = 1'b0;
    sync_in = 1'b0;
    pulses  = 0;
    busy_hi = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (sync_out) pulses++;
      if (busy) busy_hi++;
    end
    chk("reset_prio.pulses", 64'(pulses),  64'sd0);
    chk("reset_prio.busy",   64'(busy_hi), 64'sd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // SYNC_IN on the SYNC_OUT cycle: old result still pulses, new op follows.
    start(48'sd100, 48'sd7);
    for (int k = 1; k < LAT; k++) tick();
    sync_in = 1'b1;
    n_in    = 48'sd7;
    d_in    = -48'sd2;
    tick();
    sync_in = 1'b0;
    chk("coinc.old_pulse", 64'(sync_out), 64'sd1);
    chk("coinc.old_q",     64'(q),        64'sd3657);
    pulses = 0;
    at     = -1;
    q_at   = '0;
    rem_at = '0;
    for (int k = LAT + 1; k <= 2 * LAT + 1; k++) begin
      tick();
      if (k == LAT + 1) chk("coinc.busy_kept", 64'(busy), 64'sd1);
      if (sync_out) begin
        pulses++;
        at     = k;
        q_at   = q;
        rem_at = rem;
      end
    end
    chk("coinc.pulses", 64'(pulses), 64'sd1);
    chk("coinc.at",     64'(at),     64'(2 * LAT));
    chk("coinc.new_q",  64'(q_at),   -64'sd896);
    chk("coinc.new_rem",64'(rem_at), 64'sd0);

    // Restart mid-flight at cycle 5: the first operation is dropped.
    start(48'sd100, 48'sd7);
    for (int k = 1; k < 5; k++) tick();
    sync_in = 1'b1;
    n_in    = 48'sd9;
    d_in    = 48'sd3;
    tick();
    sync_in = 1'b0;
    pulses  = 0;
    at      = -1;
    q_at    = '0;
    rem_at  = '1;
    for (int k = 6; k <= 5 + LAT + 5; k++) begin
      tick();
      if (sync_out) begin
        pulses++;
        at     = k;
        q_at   = q;
        rem_at = rem;
      end
    end
    chk("restart.pulses", 64'(pulses), 64'sd1);
    chk("restart.at",     64'(at),     64'(5 + LAT));
    chk("restart.q",      64'(q_at),   64'sd768);
    chk("restart.rem",    64'(rem_at), 64'sd0);

    // Reset at cycle 10 of an operation clears held outputs and cancels the result.
    start(48'sd100, 48'sd7);
    for (int k = 1; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst     = 1'b0;
    pulses  = 0;
    busy_hi = 0;
    for (int k = 11; k <= LAT + 15; k++) begin
      tick();
      if (sync_out) pulses++;
      if (busy) busy_hi++;
    end
    chk("midrst.pulses", 64'(pulses),  64'sd0);
    chk("midrst.busy",   64'(busy_hi), 64'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
